// File: rtl/qk_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : qk_mem_writer
// Description : Streams FP32 words into the Q and K score memories. Words are
//               packed LANES at a time into one memory word; DEPTH Q words
//               are written first, then DEPTH K words. The score engine is
//               then kicked and the block waits for its completion.
// Ports       : clk                   - single clock, rising edge
//               rst                   - asynchronous reset, active low
//               start                 - one-cycle request to begin a load
//               in_valid/in_data      - FP32 input stream
//               in_ready              - stream accept (LOAD_Q / LOAD_K only)
//               Q_mem_wr_en/addr/data - Q memory write port
//               K_mem_wr_en/addr/data - K memory write port
//               Reg_WrEn              - one-cycle start pulse to score engine
//               score_done            - score engine completion (level/pulse)
//               busy                  - high whenever not IDLE
//               load_done             - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module qk_mem_writer #(
  parameter int DEPTH = 128,
  parameter int LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [31:0]                in_data,
  output logic                       in_ready,
  output logic                       Q_mem_wr_en,
  output logic [$clog2(DEPTH)-1:0]   Q_mem_wr_addr,
  output logic [32*LANES-1:0]        Q_mem_wr_data,
  output logic                       K_mem_wr_en,
  output logic [$clog2(DEPTH)-1:0]   K_mem_wr_addr,
  output logic [32*LANES-1:0]        K_mem_wr_data,
  output logic                       Reg_WrEn,
  input  logic                       score_done,
  output logic                       busy,
  output logic                       load_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int DW = 32 * LANES;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD_Q     = 3'd1;
  localparam logic [2:0] S_LOAD_K     = 3'd2;
  localparam logic [2:0] S_KICK       = 3'd3;
  localparam logic [2:0] S_WAIT_SCORE = 3'd4;
  localparam logic [2:0] S_FIN        = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_state_next;
  logic [LW-1:0] r_lane_cnt;
  logic [AW-1:0] r_word_addr;
  logic [DW-1:0] r_pack;
  logic [DW-1:0] w_pack_next;

  logic          r_q_wr_en;
  logic [AW-1:0] r_q_wr_addr;
  logic [DW-1:0] r_q_wr_data;
  logic          r_k_wr_en;
  logic [AW-1:0] r_k_wr_addr;
  logic [DW-1:0] r_k_wr_data;

  logic w_accept;
  logic w_last_lane;
  logic w_last_word;
  logic w_group_done;

  assign in_ready     = (r_state == S_LOAD_Q) || (r_state == S_LOAD_K);
  assign w_accept     = in_valid && in_ready;
  assign w_last_lane  = (r_lane_cnt == LW'(LANES - 1));
  assign w_last_word  = (r_word_addr == AW'(DEPTH - 1));
  assign w_group_done = w_accept && w_last_lane;

  // Current lane slot replaced by the incoming word; on the last lane this is
  // the complete memory word, written straight into the write-data register.
  always_comb begin
    w_pack_next = r_pack;
    w_pack_next[32*r_lane_cnt +: 32] = in_data;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:       if (start) w_state_next = S_LOAD_Q;
      // Transition on the accepting edge keeps in_ready high across the
      // Q->K boundary; the final Q write lands in the first LOAD_K cycle.
      S_LOAD_Q:     if (w_group_done && w_last_word) w_state_next = S_LOAD_K;
      S_LOAD_K:     if (w_group_done && w_last_word) w_state_next = S_KICK;
      S_KICK:       w_state_next = S_WAIT_SCORE;
      S_WAIT_SCORE: if (score_done) w_state_next = S_FIN;
      S_FIN:        w_state_next = S_IDLE;
      default:      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lane_cnt  <= '0;
      r_word_addr <= '0;
      r_pack      <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && start) begin
        r_lane_cnt  <= '0;
        r_word_addr <= '0;
        r_pack      <= '0;
      end else if (w_accept) begin
        r_pack <= w_pack_next;
        if (w_last_lane) begin
          r_lane_cnt  <= '0;
          // Wrapping at the last word restarts addressing for K.
          r_word_addr <= w_last_word ? '0 : r_word_addr + 1'b1;
        end else begin
          r_lane_cnt <= r_lane_cnt + 1'b1;
        end
      end
    end
  end

  // Write ports: strobe for one cycle, address/data hold between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q_wr_en   <= 1'b0;
      r_q_wr_addr <= '0;
      r_q_wr_data <= '0;
      r_k_wr_en   <= 1'b0;
      r_k_wr_addr <= '0;
      r_k_wr_data <= '0;
    end else begin
      r_q_wr_en <= w_group_done && (r_state == S_LOAD_Q);
      r_k_wr_en <= w_group_done && (r_state == S_LOAD_K);
      if (w_group_done && (r_state == S_LOAD_Q)) begin
        r_q_wr_addr <= r_word_addr;
        r_q_wr_data <= w_pack_next;
      end
      if (w_group_done && (r_state == S_LOAD_K)) begin
        r_k_wr_addr <= r_word_addr;
        r_k_wr_data <= w_pack_next;
      end
    end
  end

  assign Q_mem_wr_en   = r_q_wr_en;
  assign Q_mem_wr_addr = r_q_wr_addr;
  assign Q_mem_wr_data = r_q_wr_data;
  assign K_mem_wr_en   = r_k_wr_en;
  assign K_mem_wr_addr = r_k_wr_addr;
  assign K_mem_wr_data = r_k_wr_data;

  assign Reg_WrEn  = (r_state == S_KICK);
  assign busy      = (r_state != S_IDLE);
  assign load_done = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_qk_mem_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_qk_mem_writer
// Description : Self-checking bench for qk_mem_writer. A stream of words is
//               recorded per load; expected memory writes are derived by
//               grouping that stream LANES at a time, Q first then K.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qk_mem_writer;
  localparam int DEPTH = 128;
  localparam int LANES = 4;
  localparam int AW    = 7;
  localparam int DW    = 32 * LANES;
  localparam int NW    = 2 * DEPTH * LANES;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = '0;
  logic          score_done = 1'b0;
  logic          in_ready, Q_mem_wr_en, K_mem_wr_en, Reg_WrEn, busy, load_done;
  logic [AW-1:0] Q_mem_wr_addr, K_mem_wr_addr;
  logic [DW-1:0] Q_mem_wr_data, K_mem_wr_data;

  qk_mem_writer #(.DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .Q_mem_wr_en(Q_mem_wr_en), .Q_mem_wr_addr(Q_mem_wr_addr), .Q_mem_wr_data(Q_mem_wr_data),
    .K_mem_wr_en(K_mem_wr_en), .K_mem_wr_addr(K_mem_wr_addr), .K_mem_wr_data(K_mem_wr_data),
    .Reg_WrEn(Reg_WrEn), .score_done(score_done), .busy(busy), .load_done(load_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_kick = 0;
  int n_both = 0;
  logic [AW+DW-1:0] q_log[$];
  logic [AW+DW-1:0] k_log[$];
  logic [31:0]      stim[$];

  // Write monitor: logs every strobe as {addr, data}.
  always @(negedge clk) begin
    if (rst) begin
      if (Q_mem_wr_en) q_log.push_back({Q_mem_wr_addr, Q_mem_wr_data});
      if (K_mem_wr_en) k_log.push_back({K_mem_wr_addr, K_mem_wr_data});
      if (Reg_WrEn) n_kick++;
      if (Q_mem_wr_en && K_mem_wr_en) n_both++;
    end
  end

  // Reference: memory word g is stream words LANES*g .. LANES*g+LANES-1,
  // first-received word in the least significant lane.
  function automatic logic [DW-1:0] exp_word(input int g);
    logic [DW-1:0] e;
    for (int l = 0; l < LANES; l++) e[32*l +: 32] = stim[LANES*g + l];
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] w, input int gap);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 20 && in_ready !== 1'b1; n++) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams the full stim queue; optional start poke and early score_done.
  task automatic stream(input int gapmax, input int poke_at, input bit early_done);
    for (int i = 0; i < NW; i++) begin
      if (i == poke_at) pulse_start();
      if (early_done && i == NW - 1) score_done = 1'b1;
      send_word(stim[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({in_ready, busy, Reg_WrEn, load_done, Q_mem_wr_en, K_mem_wr_en} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {in_ready, busy, Reg_WrEn, load_done, Q_mem_wr_en, K_mem_wr_en});
    end
    n_vec++;
    if ({Q_mem_wr_addr, K_mem_wr_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_addr: got %h/%h required 0", Q_mem_wr_addr, K_mem_wr_addr);
    end
    n_vec++;
    if ({Q_mem_wr_data, K_mem_wr_data} !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h/%h required 0", Q_mem_wr_data, K_mem_wr_data);
    end
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({in_ready, busy} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_no_accept: in_ready/busy=%b required 00", {in_ready, busy});
    end
    in_valid = 1'b0;
  endtask

  task automatic test_lane_order();
    q_log.delete();
    stim.delete();
    pulse_start();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_busy: got %b required 1", busy);
    end
    send_word(32'h11111111, 0);
    send_word(32'h22222222, 0);
    send_word(32'h33333333, 0);
    send_word(32'h44444444, 0);
    n_vec++;
    if ({Q_mem_wr_en, Q_mem_wr_addr, Q_mem_wr_data} !==
        {1'b1, 7'd0, 128'h44444444_33333333_22222222_11111111}) begin
      n_err++;
      $display("FAIL lane_order: got en=%b addr=%h data=%h required en=1 addr=0 data=44444444333333332222222211111111",
               Q_mem_wr_en, Q_mem_wr_addr, Q_mem_wr_data);
    end
    @(negedge clk);
    n_vec++;
    if ({Q_mem_wr_en, Q_mem_wr_addr, Q_mem_wr_data} !==
        {1'b0, 7'd0, 128'h44444444_33333333_22222222_11111111}) begin
      n_err++;
      $display("FAIL write_hold: got en=%b addr=%h data=%h required en=0 and held addr/data",
               Q_mem_wr_en, Q_mem_wr_addr, Q_mem_wr_data);
    end
  endtask

  // Continues the load begun by test_lane_order up to 2 lanes of word 5.
  task automatic test_reset_mid();
    for (int i = 0; i < 4 * LANES + 2; i++) send_word($urandom, int'($urandom_range(2, 0)));
    rst = 1'b0;
    #1;
    n_vec++;
    if ({in_ready, busy, Reg_WrEn, load_done, Q_mem_wr_en, K_mem_wr_en, Q_mem_wr_addr, Q_mem_wr_data} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: en=%b addr=%h busy=%b required all 0", Q_mem_wr_en, Q_mem_wr_addr, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if (q_log.size() != 5 || q_log[4][AW+DW-1:DW] !== 7'd4) begin
      n_err++;
      $display("FAIL reset_mid_writes: got %0d writes required 5 (addr 0..4, none at 5)", q_log.size());
    end
    n_vec++;
    if ({busy, in_ready, Q_mem_wr_en} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_idle: busy/in_ready/wr_en=%b required 000", {busy, in_ready, Q_mem_wr_en});
    end
  endtask

  task automatic test_nominal();
    logic [31:0] qv[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] kv[4] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000};
    q_log.delete(); k_log.delete(); stim.delete();
    n_kick = 0; n_both = 0;
    for (int i = 0; i < NW; i++) stim.push_back((i < NW/2) ? qv[i/DEPTH] : kv[(i - NW/2)/DEPTH]);
    pulse_start();
    stream(0, -1, 1'b0);
    n_vec++;
    if ({Reg_WrEn, load_done} !== 2'b10) begin
      n_err++;
      $display("FAIL nom_kick: Reg_WrEn/load_done=%b required 10", {Reg_WrEn, load_done});
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if ({busy, Reg_WrEn, load_done} !== 3'b100) begin
      n_err++;
      $display("FAIL nom_wait: busy/Reg_WrEn/load_done=%b required 100", {busy, Reg_WrEn, load_done});
    end
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    n_vec++;
    if (load_done !== 1'b1) begin
      n_err++;
      $display("FAIL nom_load_done: got %b required 1", load_done);
    end
    @(negedge clk);
    n_vec++;
    if ({busy, load_done, n_kick, n_both} !== {1'b0, 1'b0, 32'd1, 32'd0}) begin
      n_err++;
      $display("FAIL nom_end: busy=%b load_done=%b kicks=%0d overlaps=%0d required 0 0 1 0",
               busy, load_done, n_kick, n_both);
    end
    n_vec++;
    if (q_log.size() != DEPTH || k_log.size() != DEPTH) begin
      n_err++;
      $display("FAIL nom_write_count: got q=%0d k=%0d required %0d each", q_log.size(), k_log.size(), DEPTH);
    end
    n_vec++;
    if (q_log[0] !== {7'd0, {4{32'h3F800000}}} || k_log[DEPTH-1] !== {7'd127, {4{32'h40000000}}}) begin
      n_err++;
      $display("FAIL nom_corner_words: got q0=%h k127=%h", q_log[0], k_log[DEPTH-1]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (i >= q_log.size() || i >= k_log.size() ||
          q_log[i] !== {AW'(i), exp_word(i)} || k_log[i] !== {AW'(i), exp_word(DEPTH + i)}) begin
        n_err++;
        $display("FAIL nom_write[%0d]: got q=%h k=%h required q=%h k=%h", i,
                 (i < q_log.size()) ? q_log[i] : 'x, (i < k_log.size()) ? k_log[i] : 'x,
                 {AW'(i), exp_word(i)}, {AW'(i), exp_word(DEPTH + i)});
      end
    end
  endtask

  // Random data with 0-5 cycle gaps; start poked in LOAD_K and WAIT_SCORE.
  task automatic test_gaps_start_poke();
    q_log.delete(); k_log.delete(); stim.delete();
    n_kick = 0; n_both = 0;
    for (int i = 0; i < NW; i++) stim.push_back($urandom);
    pulse_start();
    stream(5, 700, 1'b0);
    n_vec++;
    if (Reg_WrEn !== 1'b1) begin
      n_err++;
      $display("FAIL gap_kick: got %b required 1", Reg_WrEn);
    end
    @(negedge clk);
    pulse_start();
    n_vec++;
    if ({busy, in_ready, load_done} !== 3'b100) begin
      n_err++;
      $display("FAIL wait_start_ignored: busy/in_ready/load_done=%b required 100", {busy, in_ready, load_done});
    end
    score_done = 1'b1;
    @(negedge clk);
    score_done = 1'b0;
    n_vec++;
    if (load_done !== 1'b1) begin
      n_err++;
      $display("FAIL gap_load_done: got %b required 1", load_done);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, n_kick, n_both} !== {1'b0, 32'd1, 32'd0} || q_log.size() != DEPTH || k_log.size() != DEPTH) begin
      n_err++;
      $display("FAIL gap_totals: busy=%b kicks=%0d overlaps=%0d q=%0d k=%0d required 0 1 0 %0d %0d",
               busy, n_kick, n_both, q_log.size(), k_log.size(), DEPTH, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (i >= q_log.size() || i >= k_log.size() ||
          q_log[i] !== {AW'(i), exp_word(i)} || k_log[i] !== {AW'(i), exp_word(DEPTH + i)}) begin
        n_err++;
        $display("FAIL gap_write[%0d]: got q=%h k=%h required q=%h k=%h", i,
                 (i < q_log.size()) ? q_log[i] : 'x, (i < k_log.size()) ? k_log[i] : 'x,
                 {AW'(i), exp_word(i)}, {AW'(i), exp_word(DEPTH + i)});
      end
    end
  endtask

  // score_done already high before KICK: one kick, done only via WAIT_SCORE.
  task automatic test_score_early();
    q_log.delete(); k_log.delete(); stim.delete();
    n_kick = 0;
    for (int i = 0; i < NW; i++) stim.push_back($urandom);
    pulse_start();
    stream(0, -1, 1'b1);
    n_vec++;
    if ({Reg_WrEn, load_done} !== 2'b10) begin
      n_err++;
      $display("FAIL early_kick: Reg_WrEn/load_done=%b required 10", {Reg_WrEn, load_done});
    end
    @(negedge clk);
    n_vec++;
    if ({busy, Reg_WrEn, load_done} !== 3'b100) begin
      n_err++;
      $display("FAIL early_wait: busy/Reg_WrEn/load_done=%b required 100", {busy, Reg_WrEn, load_done});
    end
    @(negedge clk);
    score_done = 1'b0;
    n_vec++;
    if (load_done !== 1'b1) begin
      n_err++;
      $display("FAIL early_load_done: got %b required 1", load_done);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, n_kick} !== {1'b0, 32'd1} || k_log.size() != DEPTH ||
        k_log[DEPTH-1] !== {7'd127, exp_word(2*DEPTH - 1)}) begin
      n_err++;
      $display("FAIL early_end: busy=%b kicks=%0d k_writes=%0d required 0 1 %0d", busy, n_kick, k_log.size(), DEPTH);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lane_order();
    test_reset_mid();
    test_nominal();
    test_gaps_start_poke();
    test_score_early();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/qk_mem_writer.md
QK_MEM_WRITER -- requirements
Module: qk_mem_writer

Interface
REQ-001: Parameter DEPTH, default 128, number of 128-bit words per memory (Q and K each).
REQ-002: Parameter LANES, default 4, FP32 lanes packed per memory word.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  one-cycle request to begin a Q/K load.
REQ-006: in_valid  input  1  stream word valid.
REQ-007: in_data  input  32  FP32 stream word; bits pass through unmodified.
REQ-008: in_ready  output  1  stream word accepted when in_valid and in_ready are both high.
REQ-009: Q_mem_wr_en  output  1  Q memory write strobe.
REQ-010: Q_mem_wr_addr  output  7  Q memory write address.
REQ-011: Q_mem_wr_data  output  128  Q memory write data.
REQ-012: K_mem_wr_en, K_mem_wr_addr, K_mem_wr_data  output  1/7/128  K memory write port, same semantics as the Q port.
REQ-013: Reg_WrEn  output  1  one-cycle start pulse to the score engine.
REQ-014: score_done  input  1  score engine completion; level or pulse.
REQ-015: busy  output  1  high in every state except IDLE.
REQ-016: load_done  output  1  one-cycle pulse when the sequence completes.

Function
REQ-017: The FSM SHALL have states IDLE, LOAD_Q, LOAD_K, KICK, WAIT_SCORE and FIN.
REQ-018: In IDLE, start=1 SHALL move to LOAD_Q on the next edge and clear lane_cnt, word_addr and the pack register.
REQ-019: in_ready SHALL be 1 in LOAD_Q and LOAD_K only, combinationally from state.
- in IDLE, in_valid is not accepted.
REQ-020: Packing order:
- the k-th accepted word of a group (k = 0..3) goes to pack bits [32k+31:32k];
- lane 0 = first word received.
REQ-021: Acceptance of lane 3 SHALL cause a registered write in the next cycle:
- wr_en = 1 for exactly one cycle;
- wr_addr = word_addr;
- wr_data = the full packed word;
- word_addr then increments.
REQ-022: Q writes SHALL use word_addr 0..127, then K writes 0..127; word_addr wraps to 0 at the Q→K boundary.
REQ-023: LOAD_Q SHALL go to LOAD_K on the same edge that accepts lane 3 of Q word 127.
- in_ready stays high across the boundary with no bubble;
- the Q write for address 127 occurs in the first LOAD_K cycle.
REQ-024: LOAD_K SHALL go to KICK on the edge that accepts lane 3 of K word 127.
REQ-025: KICK SHALL assert Reg_WrEn for exactly one cycle, then go to WAIT_SCORE.
REQ-026: WAIT_SCORE SHALL hold until score_done=1, then go to FIN.
- score_done seen in KICK is ignored.
REQ-027: FIN SHALL assert load_done for one cycle, then return to IDLE.
REQ-028: in_valid gaps SHALL stall packing with no data loss and no spurious writes.
- Total accepted words per sequence = 2*DEPTH*LANES = 1024.
REQ-029: start while busy=1 SHALL be ignored and SHALL NOT restart counters.
REQ-030: Q and K write strobes SHALL never be high in the same cycle.
REQ-031: wr_addr and wr_data SHALL hold their last values when wr_en=0.

Reset
REQ-032: While rst=0, all of the following SHALL be 0:
- in_ready, busy, Reg_WrEn, load_done;
- both wr_en, wr_addr and wr_data;
- lane_cnt, word_addr and the pack register.
The state SHALL be IDLE.
REQ-033: Reset asserted mid-load SHALL discard any partially packed word.
- It SHALL NOT generate a write in the following cycle;
- after release the block waits in IDLE for a new start.

Verification
REQ-034: Nominal load:
- stimulus: start; stream 512 words of 1.0*(i+1) for Q rows i=0..3 (128 words per row), then 512 words of 0.5*(i+1) for K; then score_done.
- response: 128 Q writes, addr 0..127, Q_mem_wr_data at addr 0 = {4{0x3F800000}}; 128 K writes, K addr 127 = {4{0x40000000}}; exactly one Reg_WrEn pulse; load_done one cycle after score_done is sampled in WAIT_SCORE.
REQ-035: Lane order:
- stimulus: words 0x11111111, 0x22222222, 0x33333333, 0x44444444.
- response: Q_mem_wr_data = 0x44444444_33333333_22222222_11111111 at addr 0, one cycle after the fourth accept.
REQ-036: Random in_valid gaps of 0-5 cycles → same write sequence and data as REQ-034; no wr_en without a completed group.
REQ-037: start pulsed during LOAD_K and WAIT_SCORE → no change in state, addresses or write count.
REQ-038: rst=0 after 2 lanes of Q word 5 → no write at addr 5; all outputs 0. Then start plus a full load → writes begin at Q addr 0.
REQ-039: score_done held high before KICK → Reg_WrEn still pulses once; load_done occurs only after the WAIT_SCORE state is reached.
